// File: rtl/signed_accumulator.sv
// Saturating signed accumulator with add/subtract operands.
// Collects MAX_OPS accepted operands per frame. It presents the frame
// result for one cycle with out_valid, then restarts from zero.
// Subtraction adds the two's complement negation of the sign-extended
// operand. Everything is computed one bit wider than the accumulator, so
// negating the most negative operand is exact.
module signed_accumulator #(
   parameter int WIDTH   = 4,
   parameter int MAX_OPS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sub,
   output logic [WIDTH-1:0] acc_out,
   output logic             ovf,
   output logic             out_valid,
   output logic [3:0]       op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [3:0]       LAST_CNT = 4'(MAX_OPS);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       op_count_q, op_count_d;

   logic             accept;
   logic [WIDTH:0]   acc_ext;
   logic [WIDTH:0]   in_ext;
   logic [WIDTH:0]   operand;
   logic [WIDTH:0]   sum;
   logic             sat_pos;
   logic             sat_neg;
   logic [WIDTH-1:0] sat_val;
   logic [3:0]       count_inc;

   // The result frame is never extended: DONE always refuses input, and so does clear.
   assign in_ready = (state_q != DONE) && !clear;
   assign accept   = in_valid && in_ready;

   // Widened add/subtract followed by clamping to the signed accumulator range.
   always_comb begin
      acc_ext   = {acc_q[WIDTH-1], acc_q};
      in_ext    = {in_data[WIDTH-1], in_data};
      operand   = in_sub ? (~in_ext + (WIDTH+1)'(1)) : in_ext;
      sum       = acc_ext + operand;
      // The top two bits disagree only when the result left the WIDTH-bit range.
      sat_pos   = !sum[WIDTH] && sum[WIDTH-1];
      sat_neg   = sum[WIDTH] && !sum[WIDTH-1];
      sat_val   = sat_pos ? POS_MAX : (sat_neg ? NEG_MIN : sum[WIDTH-1:0]);
      count_inc = op_count_q + 4'd1;
   end

   // Frame sequencing. clear outranks everything, and all registers hold when nothing is accepted.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      op_count_d  = op_count_q;
      out_valid_d = 1'b0;
      if (clear) begin
         state_d    = IDLE;
         acc_d      = '0;
         ovf_d      = 1'b0;
         op_count_d = 4'd0;
      end else begin
         case (state_q)
            IDLE, RUN: begin
               if (accept) begin
                  acc_d      = sat_val;
                  ovf_d      = ovf_q | sat_pos | sat_neg;
                  op_count_d = count_inc;
                  if (count_inc == LAST_CNT) begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            DONE: begin
               // The result has been shown for its single cycle; start an empty frame.
               state_d    = IDLE;
               acc_d      = '0;
               ovf_d      = 1'b0;
               op_count_d = 4'd0;
            end
            default: begin
               state_d    = IDLE;
               acc_d      = '0;
               ovf_d      = 1'b0;
               op_count_d = 4'd0;
            end
         endcase
      end
   end

   // State and registered outputs, asynchronously cleared by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         op_count_q  <= 4'd0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         op_count_q  <= op_count_d;
      end
   end

   assign acc_out   = acc_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Self-checking bench for signed_accumulator (WIDTH=4, MAX_OPS=4).
// A behavioural reference model pushes the expected post-edge outputs into a
// scoreboard queue as each cycle is driven. Each test task pops an entry
// after the edge and compares it with the DUT outputs.
module tb_signed_accumulator;

   localparam int WIDTH   = 4;
   localparam int MAX_OPS = 4;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sub;
   logic [WIDTH-1:0] acc_out;
   logic             ovf;
   logic             out_valid;
   logic [3:0]       op_count;

   typedef struct packed {
      logic [3:0] acc;
      logic       ovf;
      logic       vld;
      logic [3:0] cnt;
   } obs_t;

   typedef struct {
      bit v;
      int d;
      bit s;
      bit c;
   } stim_t;

   obs_t sb_q[$];
   int   comp_cnt = 0;
   int   err_cnt  = 0;

   // Reference model state (0 = IDLE, 1 = RUN, 2 = DONE).
   int m_acc, m_cnt, m_state;
   bit m_ovf, m_outv;

   signed_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .acc_out   (acc_out),
      .ovf       (ovf),
      .out_valid (out_valid),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_acc = 0; m_cnt = 0; m_state = 0; m_ovf = 0; m_outv = 0;
   endtask

   // Advance the model by one clock edge and push the expected outputs.
   task automatic model_step(input bit v, input int d, input bit s, input bit c);
      int t;
      if (c) begin
         model_reset();
      end else if (m_state == 2) begin
         model_reset();
      end else if (v) begin
         t = s ? (m_acc - d) : (m_acc + d);
         if (t > 7) begin
            t = 7; m_ovf = 1;
         end else if (t < -8) begin
            t = -8; m_ovf = 1;
         end
         m_acc = t;
         m_cnt = m_cnt + 1;
         if (m_cnt == MAX_OPS) begin
            m_state = 2; m_outv = 1;
         end else begin
            m_state = 1; m_outv = 0;
         end
      end else begin
         m_outv = 0;
      end
      sb_q.push_back({4'(m_acc), m_ovf, m_outv, 4'(m_cnt)});
   endtask

   // Drive one cycle of stimulus, sample in_ready before the edge, and sample outputs 1ns after it.
   task automatic apply(input stim_t st, output bit rdy_obs, output bit rdy_exp, output obs_t o);
      in_valid = st.v;
      in_data  = 4'(st.d);
      in_sub   = st.s;
      clear    = st.c;
      #1;
      rdy_obs = in_ready;
      rdy_exp = (m_state != 2) && !st.c;
      model_step(st.v, st.d, st.s, st.c);
      @(posedge clk);
      #1;
      o = {acc_out, ovf, out_valid, op_count};
   endtask

   function automatic stim_t mk(input bit v, input int d, input bit s, input bit c);
      stim_t r;
      r.v = v; r.d = d; r.s = s; r.c = c;
      return r;
   endfunction

   task automatic test_reset();
      stim_t st[$];
      obs_t  o, e;
      bit    ro, re;
      // Power-on reset is applied from time 0.
      #1;
      comp_cnt++;
      if ({acc_out, ovf, out_valid, op_count} !== 10'b0) begin
         err_cnt++;
         $display("FAIL reset_init: got %b need %b", {acc_out, ovf, out_valid, op_count}, 10'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      st.push_back(mk(1, 3, 0, 0));
      st.push_back(mk(1, 2, 0, 0));
      foreach (st[i]) begin
         apply(st[i], ro, re, o);
         e = sb_q.pop_front();
         $display("txn reset[%0d]: acc=%0d ovf=%b vld=%b cnt=%0d rdy=%b", i, $signed(o.acc), o.ovf, o.vld, o.cnt, ro);
         comp_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL reset_pre[%0d]: got %h need %h", i, o, e);
         end
      end
      // Asynchronous reset between edges must clear the outputs with no clock edge.
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      comp_cnt++;
      if ({acc_out, ovf, out_valid, op_count} !== 10'b0) begin
         err_cnt++;
         $display("FAIL reset_async: got %b need %b", {acc_out, ovf, out_valid, op_count}, 10'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      comp_cnt++;
      if (in_ready !== 1'b1) begin
         err_cnt++;
         $display("FAIL reset_ready: got %b need 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_normal_frame();
      stim_t st[$];
      obs_t  o, e;
      bit    ro, re;
      st.push_back(mk(1, 3, 0, 0));
      st.push_back(mk(1, 2, 0, 0));
      st.push_back(mk(1, -1, 0, 0));
      st.push_back(mk(1, 1, 1, 0));
      st.push_back(mk(0, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 0));
      foreach (st[i]) begin
         apply(st[i], ro, re, o);
         e = sb_q.pop_front();
         $display("txn normal[%0d]: acc=%0d ovf=%b vld=%b cnt=%0d rdy=%b", i, $signed(o.acc), o.ovf, o.vld, o.cnt, ro);
         comp_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL normal[%0d]: got %h need %h", i, o, e);
         end
         comp_cnt++;
         if (ro !== re) begin
            err_cnt++;
            $display("FAIL normal_ready[%0d]: got %b need %b", i, ro, re);
         end
      end
   endtask

   task automatic test_pos_saturation();
      stim_t st[$];
      obs_t  o, e;
      bit    ro, re;
      st.push_back(mk(1, 7, 0, 0));
      st.push_back(mk(1, 1, 0, 0));
      st.push_back(mk(1, 2, 1, 0));
      st.push_back(mk(1, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 0));
      foreach (st[i]) begin
         apply(st[i], ro, re, o);
         e = sb_q.pop_front();
         $display("txn possat[%0d]: acc=%0d ovf=%b vld=%b cnt=%0d rdy=%b", i, $signed(o.acc), o.ovf, o.vld, o.cnt, ro);
         comp_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL possat[%0d]: got %h need %h", i, o, e);
         end
      end
   endtask

   task automatic test_neg_saturation();
      stim_t st[$];
      obs_t  o, e;
      bit    ro, re;
      st.push_back(mk(1, -8, 0, 0));
      st.push_back(mk(1, 1, 1, 0));
      st.push_back(mk(0, 0, 0, 1));
      st.push_back(mk(1, -8, 1, 0));
      st.push_back(mk(1, -8, 1, 0));
      st.push_back(mk(1, 0, 0, 0));
      st.push_back(mk(1, 7, 1, 0));
      st.push_back(mk(0, 0, 0, 0));
      foreach (st[i]) begin
         apply(st[i], ro, re, o);
         e = sb_q.pop_front();
         $display("txn negsat[%0d]: acc=%0d ovf=%b vld=%b cnt=%0d rdy=%b", i, $signed(o.acc), o.ovf, o.vld, o.cnt, ro);
         comp_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL negsat[%0d]: got %h need %h", i, o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$];
      obs_t  o, e;
      bit    ro, re;
      for (int k = 0; k < 7; k++) st.push_back(mk(1, 1, 0, 0));
      st.push_back(mk(0, 0, 0, 1));
      foreach (st[i]) begin
         apply(st[i], ro, re, o);
         e = sb_q.pop_front();
         $display("txn b2b[%0d]: acc=%0d ovf=%b vld=%b cnt=%0d rdy=%b", i, $signed(o.acc), o.ovf, o.vld, o.cnt, ro);
         comp_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL b2b[%0d]: got %h need %h", i, o, e);
         end
         comp_cnt++;
         if (ro !== re) begin
            err_cnt++;
            $display("FAIL b2b_ready[%0d]: got %b need %b", i, ro, re);
         end
      end
   endtask

   task automatic test_clear();
      stim_t st[$];
      obs_t  o, e;
      bit    ro, re;
      st.push_back(mk(1, 3, 0, 0));
      st.push_back(mk(1, 2, 0, 0));
      st.push_back(mk(1, 2, 0, 1));
      st.push_back(mk(1, 1, 0, 0));
      st.push_back(mk(0, 0, 0, 1));
      foreach (st[i]) begin
         apply(st[i], ro, re, o);
         e = sb_q.pop_front();
         $display("txn clear[%0d]: acc=%0d ovf=%b vld=%b cnt=%0d rdy=%b", i, $signed(o.acc), o.ovf, o.vld, o.cnt, ro);
         comp_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL clear[%0d]: got %h need %h", i, o, e);
         end
         comp_cnt++;
         if (ro !== re) begin
            err_cnt++;
            $display("FAIL clear_ready[%0d]: got %b need %b", i, ro, re);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_sub   = 1'b0;
      model_reset();
      test_reset();
      test_normal_frame();
      test_pos_saturation();
      test_neg_saturation();
      test_back_to_back();
      test_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/signed_accumulator.md
Name: signed_accumulator

Overview:
- Sequential stage downstream of the 4-bit two's complement negator.
- Consumes signed operands and adds or subtracts them into a running accumulator, using two's complement negation for subtraction.
- Saturates on overflow and sets a sticky overflow flag.
- After every frame of MAX_OPS accepted operands, presents the result with a one-cycle valid pulse and restarts from zero.

Parameters:
WIDTH, 4, operand/accumulator width in bits, two's complement signed
MAX_OPS, 4, accepted operands per frame (2..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: return to IDLE, zero all state
in_valid  input  1  operand present on in_data
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  signed operand
in_sub  input  1  1 = subtract in_data, 0 = add; sampled with in_data
acc_out  output  WIDTH  current accumulator value, signed
ovf  output  1  sticky: at least one saturation in current frame
out_valid  output  1  one-cycle pulse, acc_out holds frame result
op_count  output  4  operands accepted in current frame

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, acc_out=0, ovf=0, out_valid=0, op_count=0. Outputs take these values without waiting for a clock edge.
- States: IDLE (frame empty), RUN (1..MAX_OPS-1 accepted), DONE (result presentation, exactly one cycle).
- in_ready (combinational) = (state != DONE) && !clear.
- Accept = in_valid && in_ready at a rising clk edge. Registered: acc_out, op_count and ovf update on the same edge. Result is visible one cycle after in_valid is presented.
- Arithmetic is done in WIDTH+1 bits.
  - Sign-extend acc and in_data.
  - sum = acc + ext(in_data) if in_sub=0.
  - sum = acc + (~ext(in_data) + 1) if in_sub=1.
- Saturation:
  - sum > 2^(WIDTH-1)-1: acc = +max (0111) and ovf := 1.
  - sum < -2^(WIDTH-1): acc = -min (1000) and ovf := 1.
  - Otherwise acc = sum[WIDTH-1:0].
  - Subtracting -8 is exact in WIDTH+1 bits, so 0 - (-8) saturates to +7 with ovf=1.
- ovf is sticky: it is only cleared by reset, clear, or leaving DONE.
- Transitions:
  - IDLE -> RUN on accept.
  - RUN -> RUN on accept while op_count+1 < MAX_OPS.
  - RUN or IDLE -> DONE on the accept that makes op_count reach MAX_OPS.
  - DONE -> IDLE unconditionally on the next edge.
- In DONE: out_valid=1, acc_out/ovf/op_count hold the final frame values, and in_ready=0 (in_valid is ignored, not lost; the source must hold it).
- Leaving DONE: acc_out=0, ovf=0, op_count=0, out_valid=0.
- No accept: all registers hold.
- clear=1 at an edge (rst_n high): same effect as reset but synchronous. Takes priority over accept; an operand presented in that cycle is dropped (in_ready is already 0). A clear during DONE suppresses nothing already output; the next state is IDLE.
- op_count never exceeds MAX_OPS. No wrap-around of the accumulator: saturation only.

Test Plan:
- Reset mid-frame: accept 3, 2, then pull rst_n low between edges -> acc_out=0, op_count=0, ovf=0, out_valid=0 immediately; in_ready=1 after release.
- Normal frame (WIDTH=4, MAX_OPS=4): +3, +2, +(-1), sub 1 back-to-back -> acc_out 3, 5, 4, 3.
  - out_valid=1 for one cycle with acc_out=3, op_count=4, ovf=0.
  - Next cycle acc_out=0, op_count=0.
- Positive saturation: +7 then +1 -> acc_out=7, ovf=1. A following sub 2 gives 5 with ovf still 1; ovf reads 1 during the DONE pulse.
- Negative and edge saturation:
  - Fresh frame +(-8) then sub 1 -> acc_out=-8 (1000), ovf=1.
  - Fresh frame sub -8 -> acc_out=7, ovf=1.
- Backpressure: in_valid held high continuously with operand 1 -> in_ready=0 during the DONE cycle and no accept there. The held operand is accepted in the following IDLE cycle, giving acc_out=1, op_count=1.
- Clear: in RUN with acc_out=5, assert clear together with in_valid=1, in_data=2 -> in_ready=0, next cycle acc_out=0, op_count=0, state IDLE, operand not accumulated.
